signal_period_meter: RTL

Measures the half-period of a slow square wave (such as the toggling output of our clock dividers) in units of the system clock and reports the divider setting that would produce it. It is the receive-side counterpart of the divider: a signal toggling every div+1 clk cycles is reported as half_period = div. It sits next to the divider outputs for self-check and on external slow inputs for frequency monitoring.

---
 rtl/signal_period_meter.sv | 105 ++++++++++
 1 files changed

// File: rtl/signal_period_meter.sv
// Measures the half-period of a slow asynchronous square wave in clk cycles (divider setting).
// Result appears SYNC_STAGES+2 cycles after a sig_in transition; there is no backpressure.
module signal_period_meter #(
  parameter int                 WIDTH       = 26,
  parameter int                 SYNC_STAGES = 2,
  parameter int                 TOL         = 1,
  parameter logic [WIDTH-1:0]   TIMEOUT     = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic [WIDTH-1:0] half_period,
  output logic             valid,
  output logic             locked,
  output logic             timeout
);

  typedef enum logic [1:0] {IDLE, ARMED, TRACK} state_t;

  localparam logic [WIDTH:0] TOL_W = (WIDTH+1)'(TOL);

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   sig_s;
  logic                   sig_d;
  logic                   edge_det;
  logic [WIDTH-1:0]       cnt;
  logic [WIDTH-1:0]       prev;
  logic [WIDTH:0]         diff;

  assign sig_s    = sync[SYNC_STAGES-1];
  assign edge_det = sig_s ^ sig_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync  <= '0;
      sig_d <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], sig_in};
      sig_d <= sig_s;
    end
  end

  // cnt holds interval-1 at the moment an edge is seen; it parks at TIMEOUT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (edge_det) begin
      cnt <= '0;
    end else if (cnt != TIMEOUT) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    diff = '0;
    if (cnt >= prev) diff = {1'b0, cnt} - {1'b0, prev};
    else             diff = {1'b0, prev} - {1'b0, cnt};
  end

  // An edge takes priority over a coincident timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      half_period <= '0;
      valid       <= 1'b0;
      locked      <= 1'b0;
      timeout     <= 1'b0;
      prev        <= '0;
    end else begin
      valid   <= 1'b0;
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (edge_det) state <= ARMED;
        end
        ARMED: begin
          if (edge_det) begin
            half_period <= cnt;
            valid       <= 1'b1;
            prev        <= cnt;
            state       <= TRACK;
          end else if (cnt == TIMEOUT) begin
            timeout <= 1'b1;
            state   <= IDLE;
          end
        end
        TRACK: begin
          if (edge_det) begin
            half_period <= cnt;
            valid       <= 1'b1;
            locked      <= (diff <= TOL_W);
            prev        <= cnt;
          end else if (cnt == TIMEOUT) begin
            timeout <= 1'b1;
            locked  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
